// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/done handshake for the rv32i datapath.
// Single-cycle ops finish one cycle after start. Defining ALU_MULDIV_EN adds
// iterative mul/mulhu/divu/remu (one bit per cycle); when it is left undefined,
// those opcodes complete in one cycle with result 0, like the reserved codes.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`else
  typedef enum logic {IDLE, DONE} state_t;
`endif

  state_t state, state_next;

  logic               accept;
  logic               iter_op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_out;

  assign shamt = srcB[SHAMT_W-1:0];

  // Single-cycle operation result, computed straight from the live operands.
  always_comb begin
    alu_out = '0;
    case (ALUControl)
      4'b0000: alu_out = srcA + srcB;
      4'b0001: alu_out = srcA - srcB;
      4'b0010: alu_out = srcA & srcB;
      4'b0011: alu_out = srcA | srcB;
      4'b0100: alu_out = srcA ^ srcB;
      4'b0101: alu_out = WIDTH'($signed(srcA) < $signed(srcB));
      4'b0110: alu_out = WIDTH'(srcA < srcB);
      4'b0111: alu_out = srcA << shamt;
      4'b1000: alu_out = srcA >> shamt;
      4'b1001: alu_out = $signed(srcA) >>> shamt;
      default: alu_out = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);

  // op_kind = {is_div, take_high_half}: mul 00, mulhu 01, divu 10, remu 11
  logic [1:0]         op_kind;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   count;
  logic [WIDTH-1:0]   iter_result;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_new;
  logic               div_ge;

  assign iter_op = ALUControl inside {[4'b1010:4'b1101]};

  // One iteration step: shift-add multiply or restoring divide on a shared
  // accumulator (upper half = partial product / remainder, lower = multiplier / quotient).
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge   = rem_sh >= {1'b0, opnd};
    rem_new  = div_ge ? (rem_sh - {1'b0, opnd}) : rem_sh;
    acc_next = op_kind[1] ? {rem_new[WIDTH-1:0], acc[WIDTH-2:0], div_ge}
                          : {mul_sum, acc[WIDTH-1:1]};
    iter_result = op_kind[0] ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
  end
`else
  assign iter_op = 1'b0;
`endif

  // State register; reset discards any op in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and handshake outputs; start is accepted in IDLE and DONE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = iter_op ? state_t'(1) : DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
        if (start) begin
          accept     = 1'b1;
          state_next = iter_op ? state_t'(1) : DONE;
        end
      end
`ifdef ALU_MULDIV_EN
      CALC: begin
        busy = 1'b1;
        if (count == LAST) state_next = DONE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Result/zero registers and iterative datapath; result only moves into a done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      zero   <= 1'b1;
`ifdef ALU_MULDIV_EN
      acc     <= '0;
      opnd    <= '0;
      count   <= '0;
      op_kind <= '0;
`endif
    end else if (accept && !iter_op) begin
      result <= alu_out;
      zero   <= (alu_out == '0);
    end
`ifdef ALU_MULDIV_EN
    else if (accept) begin
      op_kind <= {ALUControl[2], ALUControl[0]};
      acc     <= {{WIDTH{1'b0}}, (ALUControl[2] ? srcA : srcB)};
      opnd    <= ALUControl[2] ? srcB : srcA;
      count   <= '0;
    end else if (state == CALC) begin
      acc   <= acc_next;
      count <= count + WIDTH'(1);
      if (count == LAST) begin
        result <= iter_result;
        zero   <= (iter_result == '0);
      end
    end
`endif
  end

endmodule
